// File: rtl/amiga_clk_ctrl_pkg.sv
// Shared definitions for the chipset clock sequencer: FSM states,
// phase-decode constants and E-clock constants.
// Optional E-clock generation is selected with AMIGA_CLK_ECLK_EN.
package amiga_clk_ctrl_pkg;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_STABLE = 2'd1,
        S_RUN    = 2'd2
    } clk_state_e;

    // ph[1:0] values that mark the 7 MHz rising/falling enables
    localparam logic [1:0] PH_CLK7    = 2'd3;
    localparam logic [1:0] PH_CLK7N   = 2'd1;

    // E-clock: 10 CCK periods, high for the last 4 (ecnt 6..9)
    localparam logic [3:0] E_LEN      = 4'd10;
    localparam logic [3:0] E_HI_START = 4'd6;

endpackage

// File: rtl/amiga_clk_ctrl_sync2.sv
// Two-flop synchronizer with synchronous active-low reset, used to bring
// the asynchronous MMCM lock indication into the chipset clock domain.
module amiga_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture; reset clears both stages
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/amiga_clk_ctrl.sv
// Chipset clock sequencer: synchronizes MMCM lock, holds system reset until
// lock has been stable for LOCK_CYCLES, then derives the 7 MHz enables,
// CCK, C1/C3 and (with AMIGA_CLK_ECLK_EN defined) the E-clock.
module amiga_clk_ctrl
    import amiga_clk_ctrl_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter int unsigned CNT_W       = 11
) (
    input  logic clk,
    input  logic reset_n,
    input  logic locked,
    output logic sys_rst_n,
    output logic running,
    output logic clk7_en,
    output logic clk7n_en,
    output logic cck,
    output logic c1,
    output logic c3,
    output logic eclk,
    output logic eclk_rise
);

    localparam logic [CNT_W-1:0] STAB_TERM = CNT_W'(LOCK_CYCLES - 1);

    logic             locked_s;
    clk_state_e       state_q, state_d;
    logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [2:0]       ph_q, ph_d;
    logic             run;

    amiga_sync2 u_lock_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (locked),
        .q_o    (locked_s)
    );

`ifdef AMIGA_CLK_ECLK_EN
    logic [3:0] ecnt_q, ecnt_d;

    // E-clock divider register
    always_ff @(posedge clk) begin
        if (!reset_n) ecnt_q <= '0;
        else          ecnt_q <= ecnt_d;
    end
`endif

    // Sequencer state, stability counter and phase register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_WAIT;
            stab_cnt_q <= '0;
            ph_q       <= '0;
        end else begin
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            ph_q       <= ph_d;
        end
    end

    // Next-state logic; lock loss wins over the stability terminal count
    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        ph_d       = ph_q;
`ifdef AMIGA_CLK_ECLK_EN
        ecnt_d     = ecnt_q;
`endif
        case (state_q)
            S_WAIT: begin
                if (locked_s) begin
                    state_d    = S_STABLE;
                    stab_cnt_d = '0;
                end
            end
            S_STABLE: begin
                stab_cnt_d = stab_cnt_q + 1'b1;
                if (!locked_s) begin
                    state_d = S_WAIT;
                end else if (stab_cnt_q == STAB_TERM) begin
                    state_d = S_RUN;
                    ph_d    = '0;
`ifdef AMIGA_CLK_ECLK_EN
                    ecnt_d  = '0;
`endif
                end
            end
            S_RUN: begin
                // Phase and E-count freeze on lock loss; re-entry clears them
                if (!locked_s) begin
                    state_d = S_WAIT;
                end else begin
                    ph_d = ph_q + 3'd1;
`ifdef AMIGA_CLK_ECLK_EN
                    if (ph_q == 3'd7)
                        ecnt_d = (ecnt_q == E_LEN - 4'd1) ? '0 : ecnt_q + 4'd1;
`endif
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    // Output decode from registered state and phase, gated by RUN
    always_comb begin
        run       = (state_q == S_RUN);
        sys_rst_n = run;
        running   = run;
        clk7_en   = run && (ph_q[1:0] == PH_CLK7);
        clk7n_en  = run && (ph_q[1:0] == PH_CLK7N);
        cck       = run && (ph_q <= 3'd3);
        c1        = run && (ph_q >= 3'd2) && (ph_q <= 3'd5);
        c3        = run && ((ph_q <= 3'd1) || (ph_q >= 3'd6));
`ifdef AMIGA_CLK_ECLK_EN
        eclk      = run && (ecnt_q >= E_HI_START);
        eclk_rise = run && (ph_q == 3'd7) && (ecnt_q == E_HI_START - 4'd1);
`else
        eclk      = 1'b0;
        eclk_rise = 1'b0;
`endif
    end

endmodule
